// File: rtl/efb_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the EFB slave port: whole-cycle ownership,
// round-robin on ties, owner-only ack routing and a stalled-strobe watchdog.
module efb_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       xclk,
  input  logic       sys_rst,
  input  logic       m0_cyc,
  input  logic       m0_stb,
  input  logic       m0_we,
  input  logic [7:0] m0_adr,
  input  logic [7:0] m0_dat_w,
  output logic [7:0] m0_dat_r,
  output logic       m0_ack,
  output logic       m0_err,
  input  logic       m1_cyc,
  input  logic       m1_stb,
  input  logic       m1_we,
  input  logic [7:0] m1_adr,
  input  logic [7:0] m1_dat_w,
  output logic [7:0] m1_dat_r,
  output logic       m1_ack,
  output logic       m1_err,
  output logic       s_cyc,
  output logic       s_stb,
  output logic       s_we,
  output logic [7:0] s_adr,
  output logic [7:0] s_dat_w,
  input  logic [7:0] s_dat_r,
  input  logic       s_ack,
  output logic [1:0] grant,
  output logic [7:0] tmo_count
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, nextState;
  logic [1:0] grantNext;
  logic       lastServed, lastServedNext;
  logic [7:0] wdCount, wdNext;
  logic       errFirst;
  logic       ownCyc, ownStb, ownWe, busOn;
  logic [7:0] ownAdr, ownDat;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Owner's request lines, selected by the registered grant
  always_comb begin
    ownCyc = grant[1] ? m1_cyc   : m0_cyc;
    ownStb = grant[1] ? m1_stb   : m0_stb;
    ownWe  = grant[1] ? m1_we    : m0_we;
    ownAdr = grant[1] ? m1_adr   : m0_adr;
    ownDat = grant[1] ? m1_dat_w : m0_dat_w;
  end

  always_comb begin
    nextState      = state;
    grantNext      = grant;
    lastServedNext = lastServed;
    wdNext         = 8'd0;
    case (state)
      IDLE: begin
        grantNext = 2'b00;
        // lastServed = 1 means m1 was served last, so m0 wins a tie
        if (m0_cyc && (!m1_cyc || lastServed)) begin
          nextState = OWN0;
          grantNext = 2'b01;
        end else if (m1_cyc) begin
          nextState = OWN1;
          grantNext = 2'b10;
        end
      end
      OWN0, OWN1: begin
        if (!ownCyc) begin
          nextState      = IDLE;
          grantNext      = 2'b00;
          lastServedNext = (state == OWN1);
        end else if (ownStb && !s_ack) begin
          if (wdCount == TMO_LAST) nextState = ABORT;
          else                     wdNext    = wdCount + 8'd1;
        end
      end
      ABORT: begin
        if (!ownCyc) begin
          nextState      = IDLE;
          grantNext      = 2'b00;
          lastServedNext = grant[1];
        end
      end
      default: begin
        nextState = IDLE;
        grantNext = 2'b00;
      end
    endcase
  end

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      lastServed <= 1'b1;
      wdCount    <= 8'd0;
      errFirst   <= 1'b0;
      tmo_count  <= 8'd0;
    end else begin
      state      <= nextState;
      grant      <= grantNext;
      lastServed <= lastServedNext;
      wdCount    <= wdNext;
      errFirst   <= (nextState == ABORT) && (state != ABORT);
      if ((nextState == ABORT) && (state != ABORT)) tmo_count <= satInc(tmo_count);
    end
  end

  // Slave side is live only while a master owns the bus and is not aborted
  always_comb begin
    busOn    = (state == OWN0) || (state == OWN1);
    s_cyc    = busOn & ownCyc;
    s_stb    = busOn & ownStb;
    s_we     = busOn & ownWe;
    s_adr    = busOn ? ownAdr : 8'd0;
    s_dat_w  = busOn ? ownDat : 8'd0;
    m0_ack   = (state == OWN0) & s_ack;
    m1_ack   = (state == OWN1) & s_ack;
    m0_err   = errFirst & grant[0];
    m1_err   = errFirst & grant[1];
    m0_dat_r = s_dat_r;
    m1_dat_r = s_dat_r;
  end

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Directed bench for efb_wb_arbiter with a short watchdog (TIMEOUT_CYCLES = 4).
module tb_efb_wb_arbiter;

  logic       xclk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [7:0] m0_adr = 8'd0, m0_dat_w = 8'd0, m0_dat_r;
  logic       m0_ack, m0_err;
  logic       m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [7:0] m1_adr = 8'd0, m1_dat_w = 8'd0, m1_dat_r;
  logic       m1_ack, m1_err;
  logic       s_cyc, s_stb, s_we;
  logic [7:0] s_adr, s_dat_w;
  logic [7:0] s_dat_r = 8'd0;
  logic       s_ack = 1'b0;
  logic [1:0] grant;
  logic [7:0] tmo_count;

  int compared = 0;
  int mismatched = 0;

  efb_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .xclk(xclk), .sys_rst(sys_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
    .grant(grant), .tmo_count(tmo_count)
  );

  always #5 xclk = ~xclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge xclk);
    #1;
  endtask

  task automatic forceTimeout();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    repeat (6) step();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
  endtask

  logic [1:0] expOrder [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  int         m0Left, m1Left, idx;
  logic       m0Rel, m1Rel;
  logic [1:0] prevGrant;

  initial begin
    // Reset values
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_scyc", {s_cyc, s_stb, s_we}, 3'b000);
    chk("rst_sadr", {s_adr, s_dat_w}, 16'h0000);
    chk("rst_ackerr", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
    chk("rst_tmo", tmo_count, 8'd0);
    step();
    sys_rst = 1'b1;
    step();

    // Single master write, EFB acks after two stalled cycles
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 8'h41; m0_dat_w = 8'h04;
    #1;
    chk("single_lat_scyc", s_cyc, 1'b0);
    step();
    chk("single_grant", grant, 2'b01);
    chk("single_scyc", {s_cyc, s_stb, s_we}, 3'b111);
    chk("single_sadr", {s_adr, s_dat_w}, 16'h4104);
    chk("single_ack_wait1", m0_ack, 1'b0);
    step();
    chk("single_ack_wait2", m0_ack, 1'b0);
    step();
    s_ack = 1'b1; #1;
    chk("single_m0ack", m0_ack, 1'b1);
    chk("single_m1ack", m1_ack, 1'b0);
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; #1;
    chk("single_ack_once", m0_ack, 1'b0);
    chk("single_release_scyc", s_cyc, 1'b0);
    step();
    chk("single_idle_grant", grant, 2'b00);

    // Fresh reset so the first tie goes to m0
    sys_rst = 1'b0; #1; sys_rst = 1'b1;
    step();

    // Simultaneous requesters alternate with one idle cycle between owners
    m0Left = 3; m1Left = 3; idx = 0; m0Rel = 1'b0; m1Rel = 1'b0; prevGrant = 2'b00;
    m0_adr = 8'h10; m1_adr = 8'h20;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (idx == 6 && m0Left == 0 && m1Left == 0) break;
      m0_cyc = (m0Left > 0) && !m0Rel; m0_stb = m0_cyc;
      m1_cyc = (m1Left > 0) && !m1Rel; m1_stb = m1_cyc;
      s_ack = 1'b0;
      #1;
      if (grant != prevGrant && grant != 2'b00) begin
        chk("tie_order", grant, (idx < 6) ? expOrder[idx] : 2'b11);
        chk("tie_idle_gap", prevGrant, 2'b00);
        idx++;
      end
      chk("tie_not_both", grant == 2'b11, 1'b0);
      prevGrant = grant;
      m0Rel = 1'b0; m1Rel = 1'b0;
      if (s_cyc) begin
        s_ack = 1'b1;
        if (grant == 2'b01) begin m0Left--; m0Rel = 1'b1; end
        else begin m1Left--; m1Rel = 1'b1; end
      end
      step();
    end
    chk("tie_count", idx, 6);
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    step();

    // Starvation: m0 holds the bus for 10 reads while m1 waits
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 8'h45;
    step();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 8'h73;
    #1;
    chk("starve_grant", grant, 2'b01);
    for (int i = 0; i < 10; i++) begin
      s_ack = 1'b1; s_dat_r = 8'(8'h30 + i); #1;
      chk("starve_m0ack", m0_ack, 1'b1);
      chk("starve_m1ack", m1_ack, 1'b0);
      chk("starve_dat", m0_dat_r, 8'(8'h30 + i));
      chk("starve_adr", s_adr, 8'h45);
      step();
    end
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; #1;
    chk("starve_hold", grant, 2'b01);
    chk("starve_m1wait", m1_ack, 1'b0);
    step();
    chk("starve_gap", grant, 2'b00);
    step();
    chk("starve_m1grant", grant, 2'b10);
    chk("starve_m1adr", s_adr, 8'h73);
    s_ack = 1'b1; #1;
    chk("starve_m1ack_on", m1_ack, 1'b1);
    chk("starve_m0ack_off", m0_ack, 1'b0);
    step();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    step();

    // Timeout: m1 strobes 0x73 and is never acked
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 8'h73;
    step();
    chk("tmo_grant", grant, 2'b10);
    chk("tmo_scyc1", s_cyc, 1'b1);
    step(); step(); step();
    chk("tmo_scyc4", s_cyc, 1'b1);
    chk("tmo_noerr_yet", m1_err, 1'b0);
    step();
    chk("tmo_abort_scyc", {s_cyc, s_stb, s_we}, 3'b000);
    chk("tmo_m1err", m1_err, 1'b1);
    chk("tmo_m0err", m0_err, 1'b0);
    chk("tmo_count1", tmo_count, 8'd1);
    step();
    chk("tmo_err_pulse", m1_err, 1'b0);
    chk("tmo_abort_hold", s_cyc, 1'b0);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    chk("tmo_idle", grant, 2'b00);

    // m1 drops cyc mid-strobe: immediate release, no error
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step(); step();
    m1_cyc = 1'b0; m1_stb = 1'b0; #1;
    chk("drop_scyc", s_cyc, 1'b0);
    chk("drop_err", m1_err, 1'b0);
    step();
    chk("drop_idle", grant, 2'b00);
    chk("drop_tmo", tmo_count, 8'd1);
    chk("drop_err_after", m1_err, 1'b0);

    // Ack with no owner is not forwarded
    s_ack = 1'b1; #1;
    chk("idle_ack", {m0_ack, m1_ack}, 2'b00);
    s_ack = 1'b0;
    step();

    // Ack in the same cycle the watchdog hits terminal count
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 8'h41;
    step(); step(); step(); step();
    s_ack = 1'b1; #1;
    chk("coinc_ack", m0_ack, 1'b1);
    step();
    s_ack = 1'b0; m0_stb = 1'b0; #1;
    chk("coinc_noabort", s_cyc, 1'b1);
    chk("coinc_noerr", m0_err, 1'b0);
    chk("coinc_tmo", tmo_count, 8'd1);
    m0_cyc = 1'b0;
    step();
    chk("coinc_idle", grant, 2'b00);

    // Saturation of the abort counter
    for (int i = 0; i < 254; i++) forceTimeout();
    chk("sat_255", tmo_count, 8'd255);
    forceTimeout();
    chk("sat_256", tmo_count, 8'd255);

    // Asynchronous reset mid-transaction
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    chk("rstmid_owned", grant, 2'b01);
    #2; sys_rst = 1'b0; #1;
    chk("rstmid_grant", grant, 2'b00);
    chk("rstmid_scyc", s_cyc, 1'b0);
    chk("rstmid_err", m0_err, 1'b0);
    chk("rstmid_tmo", tmo_count, 8'd0);
    step();
    sys_rst = 1'b1;
    step();
    chk("rstmid_regrant", grant, 2'b01);
    chk("rstmid_rescyc", s_cyc, 1'b1);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/efb_wb_arbiter.md
# efb_wb_arbiter

Two-master Wishbone arbiter that shares the single EFB Wishbone slave port between the I2C slave engine (master 0) and a second EFB client such as the configuration/flash engine (master 1). It grants ownership for a whole cycle, using round-robin when both masters request. It routes the slave ack only to the owner and aborts stalled cycles with a watchdog. It sits between the requesting state machines and the EFB instance, in the xclk domain.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: stalled-strobe cycles before abort; range 2..255; 8-bit counter.

Ports:
- xclk  in  1  clock.
- sys_rst  in  1  reset, asynchronous, active-low.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 Wishbone controls.
- m0_adr  in  8  master 0 address.
- m0_dat_w  in  8  master 0 write data.
- m0_dat_r  out  8  read data to master 0.
- m0_ack  out  1  ack to master 0.
- m0_err  out  1  one-cycle abort pulse to master 0.
- m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w, m1_dat_r, m1_ack, m1_err: same as m0_*, for master 1.
- s_cyc, s_stb, s_we  out  1 each  to EFB.
- s_adr  out  8  to EFB.
- s_dat_w  out  8  to EFB wb_dat_i.
- s_dat_r  in  8  from EFB wb_dat_o.
- s_ack  in  1  from EFB.
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1, 00 = none.
- tmo_count  out  8  saturating count of aborted cycles.

## Operation
- States: IDLE, OWN0, OWN1, ABORT. State, grant, last-served flag, watchdog counter and tmo_count are registered.
- IDLE:
  - only m0_cyc -> OWN0; only m1_cyc -> OWN1.
  - both -> grant the master not served last.
  - last-served resets to m1, so m0 wins the first tie.
- OWNx:
  - s_cyc/s_stb/s_we/s_adr/s_dat_w = master x signals, combinational mux on registered grant.
  - mx_ack = s_ack; the other master's ack = 0.
  - m0_dat_r = m1_dat_r = s_dat_r always.
- Release: mx_cyc low in OWNx -> IDLE, and last-served <= x. s_cyc drops the same cycle as mx_cyc (combinational).
- Ownership is held across back-to-back strobes while mx_cyc stays high. The non-owner waits indefinitely with no ack.
- Watchdog:
  - Counter increments each OWNx cycle with mx_stb=1 and s_ack=0.
  - Clears on s_ack, on mx_stb=0, and on leaving OWNx.
  - On reaching TIMEOUT_CYCLES: -> ABORT.
- ABORT:
  - s_cyc = s_stb = s_we = 0.
  - mx_err = 1 for the first ABORT cycle only.
  - tmo_count += 1, saturating at 255.
  - Stay until mx_cyc = 0 -> IDLE, last-served <= x.
- In IDLE and ABORT all s_* outputs are 0. s_adr and s_dat_w are 0 when grant = 00.

## Timing
- Reset (async, sys_rst=0): state IDLE, grant 00, s_cyc/s_stb/s_we 0, s_adr/s_dat_w 0, all acks/errs 0, tmo_count 0, watchdog 0.
- Arbitration latency: mx_cyc rises in cycle N (IDLE) -> grant and s_cyc valid in cycle N+1.
- Ack path: s_ack -> mx_ack is zero-latency combinational, so a single-cycle EFB ack reaches the master in the same cycle.
- Minimum one IDLE cycle between owners; the fastest handover is mA_cyc low at N, mB granted at N+2.
- s_ack in the same cycle the watchdog reaches terminal count: the ack wins, the counter clears, and there is no abort.
- mx_cyc dropping mid-strobe (no ack): immediate release, no err, tmo_count unchanged.
- s_ack while grant = 00: ignored, no master sees it.
- sys_rst asserted mid-cycle: all outputs to reset values immediately, with no err pulse.

## Test plan
- Single master: m0 writes adr 0x41 data 0x04, EFB acks after 2 cycles -> s_cyc rises 1 cycle after m0_cyc, m0_ack pulses once, m1_ack stays 0, grant=01.
- Simultaneous: m0_cyc and m1_cyc rise together, both hold for 3 transactions each -> order m0, m1, m0, m1..., with one IDLE cycle between owners and grant never 11.
- Starvation check: m0 holds cyc for 10 reads of adr 0x45 while m1 requests -> m1 gets no ack until m0_cyc falls, then grant=10 two cycles later.
- Timeout: TIMEOUT_CYCLES=4, m1 strobes adr 0x73 and EFB never acks -> s_cyc drops after 4 stalled cycles, m1_err is a one-cycle pulse, tmo_count=1, IDLE after m1_cyc falls.
- Boundaries: ack coincident with the terminal count -> no err. 256 forced timeouts -> tmo_count saturates at 255.
- Reset mid-transaction: sys_rst low while OWN0 with stb pending -> grant=00 and s_cyc=0 asynchronously. After release, m0_cyc high again -> granted normally.
